// File: rtl/lego_sa_feeder.sv
// -----------------------------------------------------------------------------
// lego_sa_feeder
//
// Operand feeder for the Lego systolic array. One tile job runs three phases:
//   1. LOAD_W : accept 16 weight rows from the weight source and present each
//               one to the array with load_w asserted.
//   2. STREAM : accept num_act_rows activation rows and present each one with
//               its lanes packed for the latched Lego mode.
//   3. DRAIN  : idle for DRAIN_CYC cycles so the array pipeline empties, then
//               pulse done for one cycle in DONE.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 job request, sampled only in IDLE
//   type_lego             job mode (0: 64x16, 1: 32x32, 2: 16x64, 3: illegal)
//   transpose             weight-transpose request for the job
//   num_act_rows          activation rows to stream (0 is legal)
//   busy / done / cfg_err job status; done and cfg_err are one-cycle pulses
//   w_valid/w_data/w_ready  weight source handshake (64 lanes of DATA_W)
//   a_valid/a_data/a_ready  activation source handshake (64 lanes of DATA_W)
//   sa_*                  registered drive of the array input interface
//
// Lane i of every 64-lane bus sits at bits [i*DATA_W +: DATA_W].
// -----------------------------------------------------------------------------
module lego_sa_feeder #(
  parameter int DATA_W    = 8,
  parameter int CNT_W     = 9,
  parameter int DRAIN_CYC = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [1:0]             type_lego,
  input  logic                   transpose,
  input  logic [CNT_W-1:0]       num_act_rows,
  output logic                   busy,
  output logic                   done,
  output logic                   cfg_err,
  input  logic                   w_valid,
  input  logic [64*DATA_W-1:0]   w_data,
  output logic                   w_ready,
  input  logic                   a_valid,
  input  logic [64*DATA_W-1:0]   a_data,
  output logic                   a_ready,
  output logic                   sa_valid_in,
  output logic                   sa_load_w,
  output logic                   sa_transpose_en,
  output logic [1:0]             sa_type_lego,
  output logic [64*DATA_W-1:0]   sa_weight_in,
  output logic [64*DATA_W-1:0]   sa_act_in
);

  localparam int BUS_W  = 64 * DATA_W;
  localparam int DRN_W  = (DRAIN_CYC < 1) ? 1 : $clog2(DRAIN_CYC + 1);
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN_CYC);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t             state;
  logic [3:0]         w_cnt;
  logic [CNT_W-1:0]   row_cnt;
  logic [CNT_W-1:0]   rows_q;
  logic [DRN_W-1:0]   drain_cnt;
  logic [1:0]         type_q;
  logic               tr_q;

  logic               start_ok;
  logic               start_bad;
  logic               w_fire_p0;
  logic               a_fire_p0;

  logic               vld_p1;
  logic               load_w_p1;
  logic [BUS_W-1:0]   weight_p1;
  logic [BUS_W-1:0]   act_p1;

  // Zero the lanes that the selected Lego mode does not use. Mode 3 never
  // reaches here because an illegal start is rejected in IDLE.
  function automatic logic [BUS_W-1:0] pack_lanes(input logic [BUS_W-1:0] lanes,
                                                  input logic [1:0]       mode);
    logic [BUS_W-1:0] r;
    r = lanes;
    case (mode)
      2'd0:    r[BUS_W-1:16*DATA_W] = '0;
      2'd1:    r[BUS_W-1:32*DATA_W] = '0;
      default: r = lanes;
    endcase
    return r;
  endfunction

  // ---- stage p0: handshake decode (ready depends only on state) ----
  always_comb begin
    w_ready   = (state == S_LOAD_W);
    a_ready   = (state == S_STREAM);
    w_fire_p0 = w_valid && w_ready;
    a_fire_p0 = a_valid && a_ready;
    start_ok  = (state == S_IDLE) && start && (type_lego != 2'd3);
    start_bad = (state == S_IDLE) && start && (type_lego == 2'd3);
  end

  // Control FSM. The drain counter also covers the cycle that presents the
  // final beat, so DRAIN lasts DRAIN_CYC+1 cycles and the quiet window after
  // the last presented beat is exactly DRAIN_CYC cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      w_cnt     <= '0;
      row_cnt   <= '0;
      rows_q    <= '0;
      drain_cnt <= '0;
      type_q    <= '0;
      tr_q      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      cfg_err <= start_bad;
      done    <= (state == S_DRAIN) && (drain_cnt == DRN_LAST);
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            type_q  <= type_lego;
            tr_q    <= transpose;
            rows_q  <= num_act_rows;
            w_cnt   <= '0;
            row_cnt <= '0;
            busy    <= 1'b1;
            state   <= S_LOAD_W;
          end
        end
        S_LOAD_W: begin
          if (w_fire_p0) begin
            w_cnt <= w_cnt + 4'd1;
            if (w_cnt == 4'd15) begin
              row_cnt   <= '0;
              drain_cnt <= '0;
              state     <= (rows_q == '0) ? S_DRAIN : S_STREAM;
            end
          end
        end
        S_STREAM: begin
          // Compare against rows_q-1 so an all-ones row count never wraps.
          if (a_fire_p0) begin
            row_cnt <= row_cnt + CNT_W'(1);
            if (row_cnt == rows_q - CNT_W'(1)) begin
              drain_cnt <= '0;
              state     <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          drain_cnt <= drain_cnt + DRN_W'(1);
          if (drain_cnt == DRN_LAST) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          busy   <= 1'b0;
          type_q <= '0;
          tr_q   <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // ---- stage p1: registered array drive ----
  // The data buses are reset as well so nothing stale is presented after a
  // mid-job reset. load_w rises with the accepted start and stays high for
  // every LOAD_W cycle, which keeps it asserted through stalls and through
  // the cycle that presents the 16th weight row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1    <= 1'b0;
      load_w_p1 <= 1'b0;
      weight_p1 <= '0;
      act_p1    <= '0;
    end else begin
      vld_p1    <= w_fire_p0 || a_fire_p0;
      load_w_p1 <= start_ok || (state == S_LOAD_W);
      weight_p1 <= w_fire_p0 ? w_data : '0;
      act_p1    <= a_fire_p0 ? pack_lanes(a_data, type_q) : '0;
    end
  end

  always_comb begin
    sa_valid_in     = vld_p1;
    sa_load_w       = load_w_p1;
    sa_weight_in    = weight_p1;
    sa_act_in       = act_p1;
    sa_type_lego    = type_q;
    sa_transpose_en = tr_q;
  end

endmodule
